microwave_controller: RTL and testbench
=======================================

# microwave_controller

Top-level sequencer for the microwave. It enables the keypad encoder and shifts its BCD digits into a three-digit cook-time buffer (M:SS). It then runs the cook/pause/done state machine and counts the buffer down once per second while the magnetron is on. It sits between the keypad encoder, the front-panel buttons/door switch, the 1 Hz timebase and the display/magnetron drivers.

## Interface
No parameters.
- clk  in  1  system clock; all logic on rising edge
- resetn  in  1  synchronous reset, active-low
- D  in  4  BCD digit from encoder; valid while loadn low
- loadn  in  1  encoder digit-valid, active-low
- enablen  out  1  encoder enable, active-low
- startn  in  1  start button, active-low, already debounced/synchronised
- stopn  in  1  stop/pause button, active-low, level
- clearn  in  1  clear button, active-low, level
- door_closed  in  1  1 = door shut
- tick_1hz  in  1  one-clk-wide strobe, once per second
- mins  out  4  minutes digit (BCD)
- sec_tens  out  4  tens-of-seconds digit
- sec_ones  out  4  units-of-seconds digit
- mag_on  out  1  magnetron drive
- done  out  1  one-cycle pulse on cook completion
- state  out  3  current FSM state (debug/display)

## Operation
- States and encodings: IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.
  - IDLE: buffer is 0:00.
  - SET: buffer non-zero and not cooking.
- enablen=0 in IDLE and SET; 1 in COOK, PAUSE, DONE.
- Digit entry (IDLE/SET only): accept a digit on a loadn falling edge (prev 1, now 0).
  - Shift: mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=D. The old mins value is discarded.
  - D>9 is ignored; the buffer and state are unchanged.
  - After a shift, the state is SET if the new buffer is non-zero, else IDLE.
- Start: detected on a startn falling edge (prev 1, now 0).
  - SET or PAUSE, with door_closed=1 → COOK.
  - Start in IDLE, start in DONE, or start with the door open is ignored.
- COOK: mag_on=1. On tick_1hz the buffer decrements:
  - if sec_ones>0: sec_ones-1
  - else sec_ones=9 and, if sec_tens>0, sec_tens-1
  - else sec_tens=5 and mins-1
  - Example: 1:75 counts 1:75→1:74…1:00→0:59. Tens values above 5 are legal and are not normalised.
- COOK exit:
  - Decrement from 0:01 → buffer 0:00, state DONE, done=1 for that cycle.
  - stopn=0 or door_closed=0 → PAUSE, with the buffer held.
- PAUSE: mag_on=0 and tick is ignored.
  - stopn=0 or clearn=0 → IDLE, buffer cleared.
  - Start (door closed) → COOK.
- DONE: buffer 0:00. Leaves to IDLE when clearn=0 or door_closed=0.
- Per-cycle priority: resetn > clearn > stop/door > start > tick > digit.
  - clearn=0 in any state → IDLE with the buffer cleared.
  - Stop/door has priority over tick in COOK. If tick and stop arrive in the same cycle, the tick is dropped.
- mag_on is registered and equals (next state == COOK). It is never 1 while door_closed=0 is sampled.

## Timing
- Reset values (resetn=0 at an edge): state=IDLE, mins=sec_tens=sec_ones=0, mag_on=0, done=0, enablen=0. Edge-detect history registers are set to 1.
- Reset mid-COOK takes effect at that edge: mag_on=0 and the buffer is cleared.
- Digit latency: the buffer updates on the first edge that samples loadn=0 after loadn=1.
  - Holding loadn low shifts only once.
  - A new key requires loadn to return high for at least 1 cycle.
- Start latency: COOK and mag_on=1 at the first edge that samples startn=0 after startn=1.
- Tick latency: the buffer is decremented at the same edge that samples tick_1hz=1.
- Door open in COOK: mag_on=0 at the first edge that samples door_closed=0.
- done is high for exactly one cycle, at the edge of entry into DONE.
- Digits arriving while enablen=1 are ignored, even if loadn toggles.

## Test plan
- Reset, then key 1, 3, 0 (each loadn low 2 cycles): buffer 1:30, state=SET, enablen=0. A fourth key 5 gives 3:05.
- Buffer 0:03, start with door closed, 3 ticks: mag_on rises one edge after startn falls. Buffer goes 0:02, 0:01, 0:00. done pulses 1 cycle, state=DONE, mag_on=0.
- Buffer 1:00, COOK, 1 tick → 0:59. Buffer 1:75 → 1:74. Key D=12 in SET → buffer unchanged.
- COOK at 0:45, door opened: PAUSE, mag_on=0 next edge, ticks ignored. Door closed plus start → COOK resumes from 0:45.
- COOK, with tick_1hz and stopn=0 in the same cycle: PAUSE, buffer not decremented. A further stopn=0 in PAUSE → IDLE, 0:00.
- Start in IDLE → no change. clearn=0 in SET 2:10 → IDLE 0:00. resetn=0 mid-COOK → all outputs at reset values at that edge.

Source files
------------

// File: rtl/microwave_controller.sv
// Microwave sequencer: keypad digit entry into an M:SS buffer, cook/pause/done FSM, 1 Hz countdown.
// Latency: every input takes effect at the first rising edge that samples it; outputs are registered except enablen.
// Backpressure: none. The keypad is gated via enablen, and digits or edges outside IDLE/SET are dropped.
//
// Ports:
//   clk, resetn          clock and synchronous active-low reset
//   D, loadn, enablen    keypad encoder digit, digit-valid (low), encoder enable (low)
//   startn, stopn,       front-panel buttons (active-low); door_closed = 1 when the door is shut
//   clearn, door_closed
//   tick_1hz             one-cycle strobe, once per second
//   mins, sec_tens,      BCD cook-time buffer (M:SS)
//   sec_ones
//   mag_on, done, state  magnetron drive, completion pulse, FSM state for debug/display
module microwave_controller (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       loadn,
  output logic       enablen,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       tick_1hz,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mins_d, tens_d, ones_d;
  logic       done_d;
  logic       loadn_prev, startn_prev;
  logic       digit_fall, start_fall;

  // Falling-edge detectors: a held button or key acts only once.
  assign digit_fall = loadn_prev & ~loadn;
  assign start_fall = startn_prev & ~startn;

  assign enablen = ~((state_q == IDLE) || (state_q == SET));
  assign state   = state_q;

  always_comb begin
    state_d = state_q;
    mins_d  = mins;
    tens_d  = sec_tens;
    ones_d  = sec_ones;
    done_d  = 1'b0;

    if (!clearn) begin
      state_d = IDLE;
      mins_d  = 4'd0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
    end else begin
      case (state_q)
        IDLE, SET: begin
          // A start that actually launches a cook wins over a same-cycle digit.
          if (start_fall && (state_q == SET) && door_closed) begin
            state_d = COOK;
          end else if (digit_fall && (D <= 4'd9)) begin
            mins_d  = sec_tens;
            tens_d  = sec_ones;
            ones_d  = D;
            state_d = ({sec_tens, sec_ones, D} != 12'd0) ? SET : IDLE;
          end
        end

        COOK: begin
          // Stop/door beats tick: a tick in the same cycle is dropped.
          if (!stopn || !door_closed) begin
            state_d = PAUSE;
          end else if (tick_1hz) begin
            if (sec_ones != 4'd0) begin
              ones_d = sec_ones - 4'd1;
            end else begin
              ones_d = 4'd9;
              if (sec_tens != 4'd0) begin
                tens_d = sec_tens - 4'd1;
              end else begin
                tens_d = 4'd5;
                mins_d = mins - 4'd1;
              end
            end
            if ({mins, sec_tens, sec_ones} == 12'h001) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end

        PAUSE: begin
          if (!stopn) begin
            state_d = IDLE;
            mins_d  = 4'd0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
          end else if (start_fall && door_closed) begin
            state_d = COOK;
          end
        end

        DONE: begin
          if (!door_closed) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
          mins_d  = 4'd0;
          tens_d  = 4'd0;
          ones_d  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mins        <= 4'd0;
      sec_tens    <= 4'd0;
      sec_ones    <= 4'd0;
      mag_on      <= 1'b0;
      done        <= 1'b0;
      loadn_prev  <= 1'b1;
      startn_prev <= 1'b1;
    end else begin
      state_q     <= state_d;
      mins        <= mins_d;
      sec_tens    <= tens_d;
      sec_ones    <= ones_d;
      // Following the next state keeps the magnetron off on the very edge the door opens.
      mag_on      <= (state_d == COOK);
      done        <= done_d;
      loadn_prev  <= loadn;
      startn_prev <= startn;
    end
  end

endmodule

// File: tb/tb_microwave_controller.sv
module tb_microwave_controller;

  logic       clk = 1'b0;
  logic       resetn, loadn, startn, stopn, clearn, door_closed, tick_1hz;
  logic [3:0] D;
  logic       enablen, mag_on, done;
  logic [3:0] mins, sec_tens, sec_ones;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

  microwave_controller dut (
    .clk(clk), .resetn(resetn), .D(D), .loadn(loadn), .enablen(enablen),
    .startn(startn), .stopn(stopn), .clearn(clearn), .door_closed(door_closed),
    .tick_1hz(tick_1hz), .mins(mins), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .mag_on(mag_on), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buffer kept as a digit array; time-left decrement done with a borrow chain
  // whose radix is 10 for units and 6 (reload 5) for tens of seconds.
  int  m_buf[3];   // [0]=mins [1]=tens [2]=ones
  int  m_state;
  bit  m_mag, m_done, m_ld_hist, m_st_hist, m_valid;

  function automatic bit buf_is_zero(input int b0, input int b1, input int b2);
    return (b0 + b1 + b2) == 0;
  endfunction

  task automatic m_clear();
    foreach (m_buf[i]) m_buf[i] = 0;
    m_state = S_IDLE;
  endtask

  always @(posedge clk) begin
    bit key_ev, start_ev;
    key_ev   = m_ld_hist && !loadn;
    start_ev = m_st_hist && !startn;
    m_ld_hist = loadn;
    m_st_hist = startn;
    m_done = 0;
    if (!resetn) begin
      m_clear();
      m_ld_hist = 1;
      m_st_hist = 1;
      m_valid   = 1;
    end else if (!clearn) begin
      m_clear();
    end else if (m_state == S_IDLE || m_state == S_SET) begin
      if (m_state == S_SET && start_ev && door_closed) m_state = S_COOK;
      else if (key_ev && D <= 9) begin
        m_buf[0] = m_buf[1];
        m_buf[1] = m_buf[2];
        m_buf[2] = int'(D);
        m_state = buf_is_zero(m_buf[0], m_buf[1], m_buf[2]) ? S_IDLE : S_SET;
      end
    end else if (m_state == S_COOK) begin
      if (!stopn || !door_closed) m_state = S_PAUSE;
      else if (tick_1hz) begin
        int pos;
        pos = 2;
        // borrow from the right until a non-zero digit absorbs it
        while (pos > 0 && m_buf[pos] == 0) begin
          m_buf[pos] = (pos == 2) ? 9 : 5;
          pos--;
        end
        m_buf[pos] = m_buf[pos] - 1;
        if (buf_is_zero(m_buf[0], m_buf[1], m_buf[2])) begin
          m_state = S_DONE;
          m_done  = 1;
        end
      end
    end else if (m_state == S_PAUSE) begin
      if (!stopn) m_clear();
      else if (start_ev && door_closed) m_state = S_COOK;
    end else if (m_state == S_DONE) begin
      if (!door_closed) m_state = S_IDLE;
    end
    m_mag = (m_state == S_COOK);
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("cyc_state",   state,    m_state);
      chk("cyc_mins",    mins,     m_buf[0]);
      chk("cyc_tens",    sec_tens, m_buf[1]);
      chk("cyc_ones",    sec_ones, m_buf[2]);
      chk("cyc_mag_on",  mag_on,   m_mag);
      chk("cyc_done",    done,     m_done);
      chk("cyc_enablen", enablen,  !(m_state == S_IDLE || m_state == S_SET));
      if (mag_on === 1'b1) chk("cyc_mag_door", door_closed, 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    D = d; loadn = 0; cyc(2);
    loadn = 1; cyc(1);
  endtask

  task automatic press_start();
    startn = 0; cyc(1);
    startn = 1; cyc(1);
  endtask

  task automatic tick_once();
    tick_1hz = 1; cyc(1);
    tick_1hz = 0; cyc(1);
  endtask

  task automatic do_clear();
    clearn = 0; cyc(1);
    clearn = 1; cyc(1);
  endtask

  task automatic chk_buf(input string name, input int m, input int t, input int o);
    chk({name, "_buf"}, {mins, sec_tens, sec_ones}, (m << 8) | (t << 4) | o);
  endtask

  initial begin
    resetn = 0; loadn = 1; startn = 1; stopn = 1; clearn = 1;
    door_closed = 1; tick_1hz = 0; D = 4'd0;
    cyc(2);
    chk("rst_state", state, S_IDLE);
    chk_buf("rst", 0, 0, 0);
    chk("rst_mag", mag_on, 0);
    chk("rst_done", done, 0);
    chk("rst_enablen", enablen, 0);
    resetn = 1; cyc(1);

    // digit entry
    key(4'd1); key(4'd3); key(4'd0);
    chk_buf("key130", 1, 3, 0);
    chk("key130_state", state, S_SET);
    chk("key130_enablen", enablen, 0);
    key(4'd5);
    chk_buf("key305", 3, 0, 5);
    do_clear();
    chk("clr_state", state, S_IDLE);

    // start in IDLE ignored
    press_start();
    chk("idle_start", state, S_IDLE);

    // 0:03 countdown to DONE
    key(4'd0); key(4'd0); key(4'd3);
    startn = 0; cyc(1);
    chk("start_state", state, S_COOK);
    chk("start_mag", mag_on, 1);
    startn = 1; cyc(1);
    tick_once(); chk_buf("t1", 0, 0, 2);
    tick_once(); chk_buf("t2", 0, 0, 1);
    tick_1hz = 1; cyc(1);
    chk_buf("t3", 0, 0, 0);
    chk("t3_done", done, 1);
    chk("t3_state", state, S_DONE);
    chk("t3_mag", mag_on, 0);
    tick_1hz = 0; cyc(1);
    chk("done_pulse_end", done, 0);
    press_start();
    chk("done_start", state, S_DONE);
    door_closed = 0; cyc(1); door_closed = 1; cyc(1);
    chk("done_door", state, S_IDLE);

    // minute borrow
    key(4'd1); key(4'd0); key(4'd0);
    press_start(); tick_once();
    chk_buf("borrow", 0, 5, 9);
    do_clear();

    // unnormalised tens, invalid digit
    key(4'd1); key(4'd7); key(4'd5);
    key(4'd12);
    chk_buf("d12", 1, 7, 5);
    chk("d12_state", state, S_SET);
    press_start(); tick_once();
    chk_buf("t175", 1, 7, 4);
    do_clear();

    // door open pauses, ticks ignored, resume
    key(4'd4); key(4'd5);
    press_start();
    door_closed = 0; cyc(1);
    chk("door_state", state, S_PAUSE);
    chk("door_mag", mag_on, 0);
    tick_once();
    chk_buf("pause_tick", 0, 4, 5);
    door_closed = 1;
    startn = 0; cyc(1);
    chk("resume_state", state, S_COOK);
    chk_buf("resume", 0, 4, 5);
    startn = 1; cyc(1);
    tick_once();
    chk_buf("resume_tick", 0, 4, 4);

    // tick and stop together: tick dropped; second stop clears
    tick_1hz = 1; stopn = 0; cyc(1);
    chk("stop_tick_state", state, S_PAUSE);
    chk_buf("stop_tick", 0, 4, 4);
    tick_1hz = 0; stopn = 1; cyc(1);
    stopn = 0; cyc(1);
    chk("pause_stop", state, S_IDLE);
    chk_buf("pause_stop", 0, 0, 0);
    stopn = 1; cyc(1);

    // clear in SET
    key(4'd2); key(4'd1); key(4'd0);
    chk_buf("set210", 2, 1, 0);
    clearn = 0; cyc(1);
    chk("clr210_state", state, S_IDLE);
    chk_buf("clr210", 0, 0, 0);
    clearn = 1; cyc(1);

    // start with door open ignored
    key(4'd2);
    door_closed = 0; press_start();
    chk("door_open_start", state, S_SET);
    door_closed = 1; cyc(1);
    do_clear();

    // reset mid-COOK
    key(4'd9);
    press_start();
    resetn = 0; cyc(1);
    chk("rst_cook_state", state, S_IDLE);
    chk("rst_cook_mag", mag_on, 0);
    chk_buf("rst_cook", 0, 0, 0);
    chk("rst_cook_enablen", enablen, 0);
    resetn = 1; cyc(1);

    // digits ignored while cooking
    key(4'd5);
    press_start();
    key(4'd7);
    chk_buf("cook_key", 0, 0, 5);
    chk("cook_key_state", state, S_COOK);
    do_clear();
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
